// File: rtl/neureka_package.sv
// rtl/neureka_package.sv - shared types and constants for the partial-sum replay buffer
//
// Purpose: default geometry, the per-bank state encoding, the control and flag
// structs exchanged with the replay buffer, and the tile-length clamp helper.
package neureka_package;

  localparam int unsigned NEUREKA_PE_H_DEFAULT  = 3;
  localparam int unsigned NEUREKA_PE_W_DEFAULT  = 3;
  localparam int unsigned NEUREKA_MEM_BANDWIDTH = 256;

  localparam int unsigned NEUREKA_PSUM_NR_PE_MAX = NEUREKA_PE_H_DEFAULT * NEUREKA_PE_W_DEFAULT;
  // Width of beat counters and of the nb_beats field; holds 0..NR_PE.
  localparam int unsigned NEUREKA_PSUM_CNT_W = $clog2(NEUREKA_PSUM_NR_PE_MAX + 1);

  typedef enum logic [1:0] {
    PSUM_EMPTY    = 2'd0,
    PSUM_FILLING  = 2'd1,
    PSUM_FULL     = 2'd2,
    PSUM_DRAINING = 2'd3
  } psum_bank_state_e;

  typedef struct packed {
    logic [NEUREKA_PSUM_CNT_W-1:0] nb_beats;
    logic                          replay_keep;
  } ctrl_psum_buf_t;

  typedef struct packed {
    psum_bank_state_e [1:0]        bank_state;
    logic                          wr_bank;
    logic                          rd_bank;
    logic [NEUREKA_PSUM_CNT_W-1:0] wr_cnt;
    logic [NEUREKA_PSUM_CNT_W-1:0] rd_cnt;
  } flags_psum_buf_t;

  // A zero request means a full tile; anything beyond the bank depth saturates.
  function automatic logic [NEUREKA_PSUM_CNT_W-1:0] psum_clamp_len(
    input logic [NEUREKA_PSUM_CNT_W-1:0] nb_beats,
    input int unsigned                   nr_pe
  );
    logic [NEUREKA_PSUM_CNT_W-1:0] max_len;
    max_len = NEUREKA_PSUM_CNT_W'(nr_pe);
    if (nb_beats == '0 || nb_beats > max_len) begin
      return max_len;
    end
    return nb_beats;
  endfunction

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// rtl/hwpe_stream_intf_stream.sv - valid/ready beat stream with data and byte strobes
//
// Purpose: point-to-point stream; a beat transfers when valid and ready are both high.
// Signals: clk (reference clock), valid, ready, data[DATA_WIDTH], strb[DATA_WIDTH/8].
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic clk
);

  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (input clk, output valid, output data, output strb, input ready);
  modport sink   (input clk, input valid, input data, input strb, output ready);

endinterface

// File: rtl/neureka_psum_bank.sv
// rtl/neureka_psum_bank.sv - one partial-sum bank: beat storage, tile length and fill/drain FSM
//
// Purpose: stores one tile of beats and tracks EMPTY/FILLING/FULL/DRAINING.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset (clears storage too)
//   clear_i             synchronous return to EMPTY, storage kept
//   nb_beats_i          clamped tile length, latched on the first write of a tile
//   wr_en_i/wr_idx_i    write strobe and beat index, with wr_data_i/wr_strb_i
//   rd_en_i/rd_idx_i    read handshake strobe and beat index
//   replay_keep_i       on the last read, return to FULL instead of EMPTY
//   state_o             current bank state
//   wr_last_o/rd_last_o index equals the tile's last beat
//   rd_data_o/rd_strb_o beat at rd_idx_i
module neureka_psum_bank
  import neureka_package::*;
#(
  parameter int unsigned NR_PE      = NEUREKA_PSUM_NR_PE_MAX,
  parameter int unsigned DATA_WIDTH = NEUREKA_MEM_BANDWIDTH
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic [NEUREKA_PSUM_CNT_W-1:0] nb_beats_i,
  input  logic                          wr_en_i,
  input  logic [NEUREKA_PSUM_CNT_W-1:0] wr_idx_i,
  input  logic [DATA_WIDTH-1:0]         wr_data_i,
  input  logic [DATA_WIDTH/8-1:0]       wr_strb_i,
  input  logic                          rd_en_i,
  input  logic [NEUREKA_PSUM_CNT_W-1:0] rd_idx_i,
  input  logic                          replay_keep_i,
  output psum_bank_state_e              state_o,
  output logic                          wr_last_o,
  output logic                          rd_last_o,
  output logic [DATA_WIDTH-1:0]         rd_data_o,
  output logic [DATA_WIDTH/8-1:0]       rd_strb_o
);

  localparam int unsigned CW = NEUREKA_PSUM_CNT_W;

  psum_bank_state_e        state_q, state_d;
  logic [CW-1:0]           len_q;
  logic [CW-1:0]           eff_len;
  logic [DATA_WIDTH-1:0]   data_q [NR_PE];
  logic [DATA_WIDTH/8-1:0] strb_q [NR_PE];

  // While EMPTY the length register is stale; the first write of a tile must
  // already compare against the incoming length (a 1-beat tile completes at once).
  assign eff_len   = (state_q == PSUM_EMPTY) ? nb_beats_i : len_q;
  assign wr_last_o = (wr_idx_i == eff_len - CW'(1));
  assign rd_last_o = (rd_idx_i == len_q - CW'(1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PSUM_EMPTY: begin
        if (wr_en_i) state_d = wr_last_o ? PSUM_FULL : PSUM_FILLING;
      end
      PSUM_FILLING: begin
        if (wr_en_i && wr_last_o) state_d = PSUM_FULL;
      end
      PSUM_FULL: begin
        if (rd_en_i) begin
          if (rd_last_o) state_d = replay_keep_i ? PSUM_FULL : PSUM_EMPTY;
          else           state_d = PSUM_DRAINING;
        end
      end
      PSUM_DRAINING: begin
        if (rd_en_i && rd_last_o) state_d = replay_keep_i ? PSUM_FULL : PSUM_EMPTY;
      end
      default: state_d = PSUM_EMPTY;
    endcase
    if (clear_i) state_d = PSUM_EMPTY;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PSUM_EMPTY;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      if (!clear_i && wr_en_i && state_q == PSUM_EMPTY) begin
        len_q <= nb_beats_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NR_PE); i++) begin
        data_q[i] <= '0;
        strb_q[i] <= '0;
      end
    end else if (!clear_i && wr_en_i) begin
      data_q[wr_idx_i] <= wr_data_i;
      strb_q[wr_idx_i] <= wr_strb_i;
    end
  end

  assign state_o   = state_q;
  assign rd_data_o = data_q[rd_idx_i];
  assign rd_strb_o = strb_q[rd_idx_i];

endmodule

// File: rtl/neureka_psum_replay_buffer.sv
// rtl/neureka_psum_replay_buffer.sv - ping-pong capture/replay buffer for serialized partial sums
//
// Purpose: captures tiles from the engine streamout and replays them in order
// towards the engine streamin, alternating between two banks.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   clear_i        synchronous soft clear (banks EMPTY, counters and bank pointers 0)
//   enable_i       gates push ready and pop valid; state holds while low
//   ctrl_i         nb_beats (0 = NR_PE, clamped to NR_PE), replay_keep
//   flags_o        bank states, write/read bank pointers, write/read beat counters
//   push_i         captured beats in
//   pop_o          replayed beats out
module neureka_psum_replay_buffer
  import neureka_package::*;
#(
  parameter int unsigned NR_PE      = NEUREKA_PE_H_DEFAULT * NEUREKA_PE_W_DEFAULT,
  parameter int unsigned DATA_WIDTH = NEUREKA_MEM_BANDWIDTH
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clear_i,
  input  logic                           enable_i,
  input  ctrl_psum_buf_t                 ctrl_i,
  output flags_psum_buf_t                flags_o,
  hwpe_stream_intf_stream.sink           push_i,
  hwpe_stream_intf_stream.source         pop_o
);

  localparam int unsigned CW = NEUREKA_PSUM_CNT_W;

  logic                    wr_bank_q, rd_bank_q;
  logic [CW-1:0]           wr_cnt_q, rd_cnt_q;
  logic [CW-1:0]           nb_clamped;
  logic                    push_ready, push_hs;
  logic                    pop_valid, pop_hs;

  psum_bank_state_e        bank_state [2];
  logic                    wr_last    [2];
  logic                    rd_last    [2];
  logic [DATA_WIDTH-1:0]   bank_data  [2];
  logic [DATA_WIDTH/8-1:0] bank_strb  [2];

  assign nb_clamped = psum_clamp_len(ctrl_i.nb_beats, NR_PE);

  // Ready and valid are functions of registered bank state only, so there is
  // no combinational path between the two stream sides.
  assign push_ready = enable_i && (bank_state[wr_bank_q] inside {PSUM_EMPTY, PSUM_FILLING});
  assign pop_valid  = enable_i && (bank_state[rd_bank_q] inside {PSUM_FULL, PSUM_DRAINING});
  assign push_hs    = push_i.valid && push_ready;
  assign pop_hs     = pop_valid && pop_o.ready;

  for (genvar b = 0; b < 2; b++) begin : gen_bank
    neureka_psum_bank #(
      .NR_PE      (NR_PE),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .clear_i       (clear_i),
      .nb_beats_i    (nb_clamped),
      .wr_en_i       (push_hs && (wr_bank_q == 1'(b))),
      .wr_idx_i      (wr_cnt_q),
      .wr_data_i     (push_i.data),
      .wr_strb_i     (push_i.strb),
      .rd_en_i       (pop_hs && (rd_bank_q == 1'(b))),
      .rd_idx_i      (rd_cnt_q),
      .replay_keep_i (ctrl_i.replay_keep),
      .state_o       (bank_state[b]),
      .wr_last_o     (wr_last[b]),
      .rd_last_o     (rd_last[b]),
      .rd_data_o     (bank_data[b]),
      .rd_strb_o     (bank_strb[b])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
    end else if (clear_i) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
    end else begin
      if (push_hs) begin
        if (wr_last[wr_bank_q]) begin
          wr_cnt_q  <= '0;
          wr_bank_q <= ~wr_bank_q;
        end else begin
          wr_cnt_q  <= wr_cnt_q + CW'(1);
        end
      end
      if (pop_hs) begin
        if (rd_last[rd_bank_q]) begin
          rd_cnt_q <= '0;
          // Keeping the bank leaves the read pointer in place so the tile replays.
          if (!ctrl_i.replay_keep) rd_bank_q <= ~rd_bank_q;
        end else begin
          rd_cnt_q <= rd_cnt_q + CW'(1);
        end
      end
    end
  end

  assign push_i.ready = push_ready;
  assign pop_o.valid  = pop_valid;
  assign pop_o.data   = bank_data[rd_bank_q];
  assign pop_o.strb   = bank_strb[rd_bank_q];

  assign flags_o.bank_state[0] = bank_state[0];
  assign flags_o.bank_state[1] = bank_state[1];
  assign flags_o.wr_bank       = wr_bank_q;
  assign flags_o.rd_bank       = rd_bank_q;
  assign flags_o.wr_cnt        = wr_cnt_q;
  assign flags_o.rd_cnt        = rd_cnt_q;

endmodule

// File: doc/neureka_psum_replay_buffer.md
# neureka_psum_replay_buffer

Ping-pong partial-sum buffer that is the receiving end of the engine's serialized streamout and the transmitting end of its streamin. It captures one tile of per-PE accumulator beats as they leave the engine on `store_out` (PE 0 first), then replays them in the same order on a stream wired to the engine's `load_streamin`. Partial sums can thus be carried across input-channel passes without a memory round trip. It sits beside `neureka_engine` inside the datapath, between the serializer output and the streamin FIFO.

## Interface
- `NR_PE`, default `NEUREKA_PE_H_DEFAULT*NEUREKA_PE_W_DEFAULT`: beats per full tile; depth of each bank.
- `DATA_WIDTH`, default `NEUREKA_MEM_BANDWIDTH`: beat width in bits; `strb` is `DATA_WIDTH/8`.
- `clk_i` in 1: single clock, all state on rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `clear_i` in 1: synchronous soft clear.
- `enable_i` in 1: when low, `push_i.ready` and `pop_o.valid` are forced 0 and state holds.
- `ctrl_i` in `ctrl_psum_buf_t`:
  - `nb_beats` [$clog2(NR_PE+1)]: beats in the current tile; 0 means `NR_PE`.
  - `replay_keep`: keep the bank after its replay.
- `flags_o` out `flags_psum_buf_t`:
  - `bank_state[2]` (2b each).
  - `wr_bank`, `rd_bank`.
  - `wr_cnt`, `rd_cnt`.
- `push_i` `hwpe_stream_intf_stream.sink`, `DATA_WIDTH`: captured beats (from engine streamout).
- `pop_o` `hwpe_stream_intf_stream.source`, `DATA_WIDTH`: replayed beats (to engine streamin).

## Operation
- Two banks, each `NR_PE` × (`DATA_WIDTH` data + strb) registers.
- Per-bank FSM: EMPTY → FILLING → FULL → DRAINING → EMPTY, or → FULL when `replay_keep` is set.
  - EMPTY → FILLING on the first push handshake into `wr_bank`. `nb_beats` is latched into that bank's length register at this handshake.
  - FILLING → FULL on the handshake with `wr_cnt == len-1`. `wr_cnt` then clears and `wr_bank` toggles.
  - FULL → DRAINING on the first pop handshake from `rd_bank`.
  - DRAINING → EMPTY on the handshake with `rd_cnt == len-1`, if `replay_keep` is 0 at that cycle. `rd_cnt` clears and `rd_bank` toggles.
  - DRAINING → FULL in that same case if `replay_keep` is 1. `rd_cnt` clears and `rd_bank` does not toggle, so the same tile replays again.
- `push_i.ready = enable_i & (state[wr_bank] ∈ {EMPTY, FILLING})`.
- `pop_o.valid = enable_i & (state[rd_bank] ∈ {FULL, DRAINING})`.
- Handshake rules: `pop_o.valid` never depends on `pop_o.ready`. Once valid is asserted, data, strb and valid hold until the handshake.
- Data and strb are stored unmodified. `pop_o.data` and `pop_o.strb` are muxed from `bank[rd_bank][rd_cnt]`.
- Simultaneous push into one bank and pop from the other in the same cycle is legal, full throughput.
- Both banks non-EMPTY with `wr_bank` FULL: push is stalled.
- `nb_beats > NR_PE` is clamped to `NR_PE`.
- `clear_i` has priority over handshakes:
  - all banks go to EMPTY;
  - counters, `wr_bank` and `rd_bank` go to 0;
  - data registers are not cleared.
- Reset mid-transfer: the same as clear, plus data registers go to 0.

## Timing
- Reset values:
  - `push_i.ready` = `enable_i`;
  - `pop_o.valid` = 0, `pop_o.data` = 0, `pop_o.strb` = 0;
  - `bank_state` = EMPTY/EMPTY, every counter = 0, `wr_bank` = `rd_bank` = 0.
- Latency: last capture handshake at cycle t gives `pop_o.valid` = 1 at t+1.
- Throughput: one beat per cycle on each side.
- No combinational path from `pop_o.ready` to `push_i.ready`, or the reverse.

## Structure
- `ctrl_psum_buf_t`, `flags_psum_buf_t` and the 2-bit bank-state enum go in `neureka_package`.
- One natural sub-module, `neureka_psum_bank`. It holds the register array, the length register and the per-bank FSM, and is instantiated twice. The top level holds `wr_bank`/`rd_bank`, the counters and the stream muxing.

## Test plan
- Full tile, `NR_PE=9`, `nb_beats=0`:
  - push data = beat index 0..8 back-to-back;
  - `pop_o.valid` rises the cycle after beat 8;
  - pop yields 0..8 in order, 9 cycles with `ready` held high;
  - bank0 ends EMPTY, `rd_bank=1`.
- Ping-pong:
  - push tile A (9 beats) then tile B while A drains with `pop_o.ready` high;
  - no push stall during B;
  - pop order A0..A8, B0..B8.
- Backpressure: with both banks FULL, a third tile's first beat sees `ready=0` until one pop completes A8.
- Partial tile `nb_beats=4`, then `replay_keep=1` on the first drain:
  - replay gives 0..3 twice;
  - the second drain, with `replay_keep=0`, frees the bank.
- Random `pop_o.ready` toggling:
  - data and valid stable while `ready=0`;
  - compare against a scoreboard over 100 random tiles.
- `clear_i` asserted at beat 5 of a fill:
  - next cycle both banks EMPTY, `wr_cnt=0`, `pop_o.valid=0`.
- `rst_ni` asserted mid-drain: all outputs go immediately to their reset values.
